sys_seq: RTL and testbench
==========================

# sys_seq

Host-side sequencer sitting directly upstream of the 2x2 systolic array top. It turns a 16-bit command stream (valid/ready) into the array's ibus write/read traffic: it loads A/B operand words, kicks the start register, polls the status register until done or timeout, and reads the result words back. Results and a final status word go out on a 16-bit result stream. A UART or debug bridge feeds it, so the array never sees host protocol details.

## Interface
- `LOAD_BASE`, 16'h0000: ibus address of first operand word; payload words are written to consecutive addresses.
- `CTRL_ADR`, 16'h8000: start register address; the start write data is 16'h0001.
- `STAT_ADR`, 16'h8001: status register address; bit0 = done.
- `RES_BASE`, 16'h4000: ibus address of first result word.
- `POLL_GAP`, 4: idle cycles between status reads, minimum 1.
- `TIMEOUT`, 255: maximum status reads before giving up, range 1..65535.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: command word valid.
- `s_ready` out 1: command word accepted when `s_valid & s_ready`.
- `s_data` in 16: command word.
- `m_valid` out 1: result word valid.
- `m_ready` in 1: downstream accepts the result word.
- `m_data` out 16: result or status word.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `err` out 1: sticky timeout flag; cleared by the next header.
- `ren` out 1: ibus read strobe.
- `ibus_radr` out 16: read address.
- `ibus_rdata` in 16: read data, valid exactly 1 cycle after `ren`.
- `wen` out 1: ibus write strobe.
- `ibus_wadr` out 16: write address.
- `ibus_wdata` out 16: write data.

## Operation
- Frame layout: header H, then H[7:0] = LEN payload words.
  - H[11:8] = RCNT, the number of result words (0..15).
  - H[15] = GO. When GO=0, the frame only loads; no start, poll or status word is issued.
- FSM states: IDLE, LOAD, START, POLL, PWAIT, GAP, READ, RWAIT, OUT, STAT.
- IDLE: `s_ready`=1. On header accept:
  - latch LEN, RCNT and GO; clear `err`.
  - go to LOAD if LEN≠0; else START if GO; else stay in IDLE.
- LOAD: `s_ready`=1. Each accepted word k (0..LEN-1) produces one write to LOAD_BASE+k (16-bit wrap).
  - After word LEN-1: go to START if GO, else IDLE.
- START: one write of 16'h0001 to CTRL_ADR; go to POLL with the poll counter cleared.
- POLL: one-cycle `ren` at STAT_ADR, poll counter +1; then PWAIT.
- PWAIT: sample `ibus_rdata`.
  - bit0=1: go to READ if RCNT≠0, else STAT.
  - bit0=0 and counter=TIMEOUT: set `err`, go to STAT. No result reads are issued.
  - otherwise: go to GAP.
- GAP: wait POLL_GAP cycles, then POLL.
- READ: one-cycle `ren` at RES_BASE+j; then RWAIT.
- RWAIT: capture `ibus_rdata` into the `m_data` register, assert `m_valid`, go to OUT.
- OUT: hold `m_valid`/`m_data` until `m_ready`. Then j+1: back to READ if j+1<RCNT, else STAT.
- STAT: present {err, 7'b0, RCNT-or-0 padded to 8 bits}.
  - RCNT field is reported as 0 on timeout.
  - Hold until `m_ready`, then go to IDLE.
- At most one ibus read is outstanding. `ren` and `wen` are never high in the same cycle.
- `s_ready`=0 in every state except IDLE and LOAD. Extra input words wait and are not dropped.

## Timing
- Reset (async): state=IDLE and all counters 0.
  - Outputs after reset: `s_ready`=1; `m_valid`, `m_data`, `busy`, `err`, `ren`, `wen`, `ibus_radr`, `ibus_wadr`, `ibus_wdata` = 0.
- Write path is registered. A word accepted in cycle t gives `wen`=1 with its address and data in cycle t+1. Sustained rate is 1 word/cycle.
- The START write is 1 cycle after the last LOAD write when the stream is back-to-back.
- Status read: `ren` in cycle t, sample in t+1. The next `ren` is in t+2+POLL_GAP.
- Result read: `ren` in cycle t, `m_valid` from t+2. With `m_ready` tied high, read j+1 `ren` is in t+3, so throughput is 1 word per 3 cycles.
- `m_data` is stable while `m_valid`=1 and `m_ready`=0. `m_valid` drops the cycle after the handshake.
- Reset mid-frame: everything aborts immediately. Partial writes are not undone. A pending `m_valid` is discarded.

## Test plan
- Load-only: H=16'h0003, then words A1/A2/A3 back-to-back -> three `wen` pulses to 0x0000..0x0002 with data A1..A3 in consecutive cycles; no START write; `busy` falls after the third write.
- Full run: H=16'h8404 plus 4 words; status model sets bit0 on the 3rd read; results R0..R3 at 0x4000..3 -> START write 16'h0001 to 0x8000; exactly 3 status reads; m stream carries R0,R1,R2,R3 then 16'h0004; `err`=0.
- Timeout: TIMEOUT=5, status never done, H=16'h8200 -> exactly 5 status reads spaced 2+POLL_GAP cycles; no reads at 0x4000; status word 16'h8000; `err`=1 until the next header.
- Backpressure: full run with `m_ready` low for 10 cycles on R1 -> R1 held stable; no further `ren` until the handshake; order is preserved.
- Input stall: `s_valid` toggled 1/0 during LOAD of 6 words -> addresses remain contiguous 0..5; `s_ready`=0 from START until return to IDLE.
- Async reset asserted during OUT -> all outputs 0 immediately; the next frame after release runs normally.

Source files
------------

// File: rtl/sys_seq.sv
// Host-side sequencer for the 2x2 systolic array: loads operands, starts the
// array, polls status with timeout and streams the result words back.
module sys_seq #(
    parameter logic [15:0] LOAD_BASE = 16'h0000,
    parameter logic [15:0] CTRL_ADR  = 16'h8000,
    parameter logic [15:0] STAT_ADR  = 16'h8001,
    parameter logic [15:0] RES_BASE  = 16'h4000,
    parameter int unsigned POLL_GAP  = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_data,
    output logic        busy,
    output logic        err,
    output logic        ren,
    output logic [15:0] ibus_radr,
    input  logic [15:0] ibus_rdata,
    output logic        wen,
    output logic [15:0] ibus_wadr,
    output logic [15:0] ibus_wdata
);

    typedef enum logic [3:0] {
        IDLE, LOAD, START, POLL, PWAIT, GAP, READ, RWAIT, OUT, STAT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [3:0]  rcnt_q, rcnt_d;
    logic        go_q, go_d;
    logic        err_q, err_d;
    logic [7:0]  ldx_q, ldx_d;
    logic [3:0]  rdx_q, rdx_d;
    logic        kick_q, kick_d;
    logic [15:0] poll_q, poll_d;
    logic [15:0] gap_q, gap_d;
    logic        wen_q, wen_d;
    logic [15:0] wadr_q, wadr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        m_valid_q, m_valid_d;
    logic [15:0] m_data_q, m_data_d;
    logic        s_fire;

    assign s_ready    = (state_q == IDLE) || (state_q == LOAD);
    assign s_fire     = s_valid && s_ready;
    assign busy       = (state_q != IDLE);
    assign err        = err_q;
    assign ren        = (state_q == POLL) || (state_q == READ);
    assign ibus_radr  = (state_q == POLL) ? STAT_ADR :
                        (state_q == READ) ? RES_BASE + {12'h000, rdx_q} :
                        16'h0000;
    assign wen        = wen_q;
    assign ibus_wadr  = wadr_q;
    assign ibus_wdata = wdata_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        rcnt_d    = rcnt_q;
        go_d      = go_q;
        err_d     = err_q;
        ldx_d     = ldx_q;
        rdx_d     = rdx_q;
        kick_d    = kick_q;
        poll_d    = poll_q;
        gap_d     = gap_q;
        wen_d     = 1'b0;
        wadr_d    = wadr_q;
        wdata_d   = wdata_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        unique case (state_q)
            IDLE: if (s_fire) begin
                len_d  = s_data[7:0];
                rcnt_d = s_data[11:8];
                go_d   = s_data[15];
                err_d  = 1'b0;
                ldx_d  = 8'h00;
                kick_d = 1'b0;
                if (s_data[7:0] != 8'h00) state_d = LOAD;
                else if (s_data[15])      state_d = START;
            end
            LOAD: if (s_fire) begin
                wen_d   = 1'b1;
                wadr_d  = LOAD_BASE + {8'h00, ldx_q};
                wdata_d = s_data;
                ldx_d   = ldx_q + 8'd1;
                if (ldx_q == len_q - 8'd1)
                    state_d = go_q ? START : IDLE;
            end
            // Two cycles so the registered start write never lands on a poll read.
            START: begin
                if (!kick_q) begin
                    wen_d   = 1'b1;
                    wadr_d  = CTRL_ADR;
                    wdata_d = 16'h0001;
                    kick_d  = 1'b1;
                end else begin
                    poll_d  = 16'h0000;
                    state_d = POLL;
                end
            end
            POLL: begin
                poll_d  = poll_q + 16'd1;
                state_d = PWAIT;
            end
            PWAIT: begin
                if (ibus_rdata[0]) begin
                    rdx_d   = 4'h0;
                    state_d = (rcnt_q != 4'h0) ? READ : STAT;
                end else if (poll_q == 16'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = STAT;
                end else begin
                    gap_d   = 16'h0000;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == 16'(POLL_GAP - 1)) state_d = POLL;
                else gap_d = gap_q + 16'd1;
            end
            READ: state_d = RWAIT;
            RWAIT: begin
                m_data_d  = ibus_rdata;
                m_valid_d = 1'b1;
                state_d   = OUT;
            end
            OUT: if (m_ready) begin
                m_valid_d = 1'b0;
                rdx_d     = rdx_q + 4'd1;
                state_d   = (rdx_q == rcnt_q - 4'd1) ? STAT : READ;
            end
            STAT: begin
                if (!m_valid_q) begin
                    m_valid_d = 1'b1;
                    m_data_d  = {err_q, 7'h00, 4'h0, err_q ? 4'h0 : rcnt_q};
                end else if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            len_q     <= 8'h00;
            rcnt_q    <= 4'h0;
            go_q      <= 1'b0;
            err_q     <= 1'b0;
            ldx_q     <= 8'h00;
            rdx_q     <= 4'h0;
            kick_q    <= 1'b0;
            poll_q    <= 16'h0000;
            gap_q     <= 16'h0000;
            wen_q     <= 1'b0;
            wadr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            m_valid_q <= 1'b0;
            m_data_q  <= 16'h0000;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            rcnt_q    <= rcnt_d;
            go_q      <= go_d;
            err_q     <= err_d;
            ldx_q     <= ldx_d;
            rdx_q     <= rdx_d;
            kick_q    <= kick_d;
            poll_q    <= poll_d;
            gap_q     <= gap_d;
            wen_q     <= wen_d;
            wadr_q    <= wadr_d;
            wdata_q   <= wdata_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

endmodule

// File: tb/tb_sys_seq.sv
// Directed bench for sys_seq with an ibus status/result model and
// write/read/result logs collected on every rising edge.
module tb_sys_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid, s_ready, m_valid, m_ready;
    logic [15:0] s_data, m_data;
    logic        busy, err, ren, wen;
    logic [15:0] ibus_radr, ibus_wadr, ibus_wdata;
    logic [15:0] ibus_rdata = 16'h0000;

    always #5 clk = ~clk;

    sys_seq #(.TIMEOUT(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .err(err),
        .ren(ren), .ibus_radr(ibus_radr), .ibus_rdata(ibus_rdata),
        .wen(wen), .ibus_wadr(ibus_wadr), .ibus_wdata(ibus_wdata)
    );

    typedef struct { logic [15:0] adr; logic [15:0] dat; int cyc; } wr_t;
    typedef struct { logic [15:0] adr; int cyc; } rd_t;

    wr_t         wlog[$];
    rd_t         rlog[$];
    logic [15:0] mlog[$];
    logic [15:0] res [4];
    int cyc = 0, overlap = 0, stat_total = 0;
    int stat_base = 0, done_at = 0;
    int vecs = 0, miss = 0;
    int wb, rb, mb;

    always @(posedge clk) begin
        int n;
        cyc <= cyc + 1;
        if (ren && wen) overlap <= overlap + 1;
        if (wen) wlog.push_back('{ibus_wadr, ibus_wdata, cyc});
        if (ren) begin
            rlog.push_back('{ibus_radr, cyc});
            if (ibus_radr == 16'h8001) begin
                n = stat_total + 1 - stat_base;
                stat_total <= stat_total + 1;
                ibus_rdata <= (done_at != 0 && n >= done_at) ? 16'h0001 : 16'h0000;
            end else begin
                ibus_rdata <= res[ibus_radr[1:0]];
            end
        end
        if (m_valid && m_ready) mlog.push_back(m_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        wb = wlog.size();
        rb = rlog.size();
        mb = mlog.size();
        stat_base = stat_total;
    endtask

    task automatic send(input logic [15:0] w);
        int k = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("send_accept", 32'(s_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_m(input int n, input string tag);
        int k = 0;
        while (mlog.size() - mb < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(mlog.size() - mb >= n), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int k, sr, stab;
        logic [15:0] hold;
        s_valid = 1'b0;
        s_data  = 16'h0000;
        m_ready = 1'b1;
        res = '{16'h1110, 16'h2220, 16'h3330, 16'h4440};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_flags", 32'({m_valid, busy, err, ren, wen}), 32'd0);
        chk("rst_mdata", 32'(m_data), 32'd0);
        chk("rst_bus", {ibus_wadr, ibus_wdata} | 32'(ibus_radr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // load-only frame
        mark();
        send(16'h0003);
        send(16'h00A1);
        send(16'h00A2);
        send(16'h00A3);
        s_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("ld_nwr", 32'(wlog.size() - wb), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("ld_adr", 32'(wlog[wb+i].adr), 32'(i));
            chk("ld_dat", 32'(wlog[wb+i].dat), 32'h00A1 + 32'(i));
        end
        chk("ld_b2b", 32'(wlog[wb+2].cyc - wlog[wb].cyc), 32'd2);
        chk("ld_nrd", 32'(rlog.size() - rb), 32'd0);
        chk("ld_busy", 32'(busy), 32'd0);

        // full run
        mark();
        done_at = 3;
        send(16'h8404);
        for (int i = 0; i < 4; i++) send(16'hD000 + 16'(i));
        s_valid = 1'b0;
        wait_m(5, "full_done");
        chk("full_nwr", 32'(wlog.size() - wb), 32'd5);
        chk("full_start", {wlog[wb+4].adr, wlog[wb+4].dat}, 32'h8000_0001);
        chk("full_st_cyc", 32'(wlog[wb+4].cyc - wlog[wb+3].cyc), 32'd1);
        chk("full_nrd", 32'(rlog.size() - rb), 32'd7);
        sr = 0;
        for (int i = rb; i < rlog.size(); i++)
            if (rlog[i].adr == 16'h8001) sr++;
        chk("full_nstat", 32'(sr), 32'd3);
        chk("full_gap", 32'(rlog[rb+1].cyc - rlog[rb].cyc), 32'd6);
        for (int j = 0; j < 4; j++)
            chk("full_radr", 32'(rlog[rb+3+j].adr), 32'h4000 + 32'(j));
        chk("full_rrate", 32'(rlog[rb+4].cyc - rlog[rb+3].cyc), 32'd3);
        for (int j = 0; j < 4; j++)
            chk("full_res", 32'(mlog[mb+j]), 32'(res[j]));
        chk("full_stat", 32'(mlog[mb+4]), 32'h0004);
        chk("full_err", 32'(err), 32'd0);

        // timeout
        mark();
        done_at = 0;
        send(16'h8200);
        s_valid = 1'b0;
        wait_m(1, "to_done");
        chk("to_nrd", 32'(rlog.size() - rb), 32'd5);
        k = 0;
        for (int i = rb; i < rlog.size(); i++)
            if (rlog[i].adr != 16'h8001) k++;
        chk("to_nores", 32'(k), 32'd0);
        chk("to_gap", 32'(rlog[rb+4].cyc - rlog[rb+3].cyc), 32'd6);
        chk("to_stat", 32'(mlog[mb]), 32'h8000);
        repeat (5) @(negedge clk);
        chk("to_err_sticky", 32'(err), 32'd1);

        // backpressure on R1
        mark();
        done_at = 1;
        send(16'h8402);
        chk("bp_err_clr", 32'(err), 32'd0);
        send(16'hE000);
        send(16'hE001);
        s_valid = 1'b0;
        k = 0;
        while (!(m_valid && m_data == res[1]) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("bp_seen_r1", 32'(m_data), 32'(res[1]));
        m_ready = 1'b0;
        hold = m_data;
        sr = rlog.size();
        stab = 0;
        repeat (10) begin
            @(negedge clk);
            if (!m_valid || m_data !== hold) stab++;
        end
        chk("bp_stable", 32'(stab), 32'd0);
        chk("bp_noread", 32'(rlog.size() - sr), 32'd0);
        m_ready = 1'b1;
        wait_m(5, "bp_done");
        for (int j = 0; j < 4; j++)
            chk("bp_order", 32'(mlog[mb+j]), 32'(res[j]));
        chk("bp_stat", 32'(mlog[mb+4]), 32'h0004);

        // input stall, then a waiting header
        mark();
        done_at = 2;
        send(16'h8006);
        for (int i = 0; i < 6; i++) begin
            send(16'hC000 + 16'(i));
            if (i < 5) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
        end
        s_valid = 1'b1;
        s_data  = 16'h0001;
        k = 0;
        while (!s_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("st_idle_first", 32'({busy, 8'(mlog.size() - mb)}), 32'h001);
        @(negedge clk);
        send(16'hBEEF);
        s_valid = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            chk("st_adr", 32'(wlog[wb+i].adr), 32'(i));
            chk("st_dat", 32'(wlog[wb+i].dat), 32'hC000 + 32'(i));
        end
        chk("st_start", {wlog[wb+6].adr, wlog[wb+6].dat}, 32'h8000_0001);
        chk("st_next", {wlog[wb+7].adr, wlog[wb+7].dat}, 32'h0000_BEEF);
        chk("st_stat", 32'(mlog[mb]), 32'h0000);

        // async reset during OUT
        mark();
        done_at = 1;
        m_ready = 1'b0;
        send(16'h8100);
        s_valid = 1'b0;
        k = 0;
        while (!m_valid && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("ar_inout", 32'(m_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_flags", 32'({m_valid, busy, err, ren, wen, s_ready}), 32'd1);
        chk("ar_mdata", 32'(m_data), 32'd0);
        chk("ar_bus", {ibus_wadr, ibus_wdata} | 32'(ibus_radr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        mark();
        send(16'h8201);
        send(16'h5555);
        s_valid = 1'b0;
        wait_m(3, "ar_done");
        chk("ar_wr", {wlog[wb].adr, wlog[wb].dat}, 32'h0000_5555);
        chk("ar_r0", 32'(mlog[mb]), 32'(res[0]));
        chk("ar_r1", 32'(mlog[mb+1]), 32'(res[1]));
        chk("ar_stat", 32'(mlog[mb+2]), 32'h0002);
        chk("ren_wen_overlap", 32'(overlap), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
